dh_exchange_ctrl: RTL and testbench
===================================

Name: dh_exchange_ctrl

Overview:
Sequencer for one Diffie-Hellman key exchange. It drives a shared modular-exponentiation engine (start/done handshake) twice: first for the public key A = g^a mod p, then for the shared secret s = B^a mod p. It exchanges public values with the peer, checks the peer's confirmation value against s, and reports a 48-bit ASCII verdict on `status`. It sits between the host/link interface and the modexp datapath.

Parameters:
WIDTH, 16, bit width of p, g, keys and secret
TIMEOUT, 1023, maximum cycles spent in any wait state before aborting

Ports:
clk  in  1  clock
rst  in  1  reset
start  in  1  begin an exchange; sampled only in IDLE
priv_key  in  WIDTH  private exponent a; captured at start
base_g  in  WIDTH  generator g; captured at start
mod_p  in  WIDTH  modulus p; captured at start
peer_pub  in  WIDTH  peer public value B
peer_pub_valid  in  1  qualifies peer_pub
peer_chk  in  WIDTH  peer confirmation value (peer's computed secret)
peer_chk_valid  in  1  qualifies peer_chk
exp_start  out  1  one-cycle pulse to the modexp engine
exp_base  out  WIDTH  engine base operand
exp_exp  out  WIDTH  engine exponent operand
exp_mod  out  WIDTH  engine modulus operand
exp_done  in  1  engine result valid, one-cycle pulse
exp_result  in  WIDTH  engine result
pub_key  out  WIDTH  own public value A
pub_valid  out  1  one-cycle pulse when pub_key is presented
shared_key  out  WIDTH  computed secret s; held until the next start
busy  out  1  high in every state except IDLE and DONE
done  out  1  one-cycle pulse on entry to DONE
status  out  48  ASCII verdict

Behaviour:
- Interface: single clock `clk`. `rst` is synchronous and active-high.
- Reset values: all registers and outputs are 0, state is IDLE, status = 0.
- Status codes:
  - 0x414343455054 "ACCEPT"
  - 0x52454A454354 "REJECT"
  - 0x54494D4F5554 "TIMOUT"
  - status holds its value until the next accepted start, which clears it to 0.
- States: IDLE, CALC_PUB, WAIT_PUB, SEND_PUB, WAIT_PEER, CALC_SEC, WAIT_SEC, WAIT_CHK, DONE.
- IDLE:
  - start=1: capture a, g, p; clear shared_key and the peer-B-valid flag.
  - If p<3 or a==0 or g<2 or g>=p: go to DONE with REJECT.
  - Otherwise go to CALC_PUB.
- CALC_PUB: exp_start=1 for exactly this cycle, with operands (g, a, p); go to WAIT_PUB.
- WAIT_PUB: on exp_done, register exp_result into pub_key and go to SEND_PUB.
- SEND_PUB: pub_valid=1 for one cycle; go to WAIT_PEER.
- Peer B capture:
  - peer_pub_valid is accepted in any state from CALC_PUB through WAIT_PEER.
  - The first valid B is captured; later ones are ignored until the next start.
- WAIT_PEER: once B is held, check range. 2 <= B <= p-2 goes to CALC_SEC; otherwise DONE with REJECT.
- CALC_SEC: exp_start pulse with operands (B, a, p); go to WAIT_SEC.
- WAIT_SEC: on exp_done, register shared_key and go to WAIT_CHK.
- WAIT_CHK:
  - On peer_chk_valid, compare with shared_key. Equal gives ACCEPT, unequal gives REJECT; go to DONE.
  - peer_chk_valid is ignored outside WAIT_CHK.
- DONE: done pulse on the entry cycle. Return to IDLE on the next cycle.
- Timeout:
  - Cycle counter (ceil(log2(TIMEOUT+1)) bits) clears on every state change.
  - It increments in WAIT_PUB, WAIT_PEER, WAIT_SEC and WAIT_CHK.
  - Reaching TIMEOUT goes to DONE with TIMOUT.
  - exp_done or valid arriving in the same cycle as the timeout wins; timeout is not taken.
- Stray inputs:
  - exp_done outside WAIT_PUB/WAIT_SEC is ignored.
  - start while busy is ignored.
- Latency: start to exp_start is 1 cycle. exp_done to pub_valid is 1 cycle. exp_done (secret) to readiness for peer_chk is 1 cycle.
- rst mid-operation returns to IDLE immediately. Any engine operation in flight is abandoned; a later exp_done is ignored.
- Operand outputs exp_base/exp_exp/exp_mod are registered and stable from the exp_start cycle until exp_done.

Decomposition:
- Shared package dh_pkg holds:
  - state encoding constants
  - the three 48-bit ASCII status constants
  - WIDTH default
- Natural sub-module: dh_wait_timer, the clearable saturating timeout counter with a `expired` flag.
- The FSM and operand muxing stay in dh_exchange_ctrl.

Test Plan:
- Nominal exchange (bench uses a behavioural modexp with 5-cycle latency): p=23, g=5, a=6. Expect pub_key=8 with one pub_valid pulse. Drive peer_pub=19: expect shared_key=2. Drive peer_chk=2: expect status=ACCEPT, one done pulse, busy low afterwards.
- Wrong confirmation: same setup, peer_chk=3 -> status=REJECT, shared_key stays 2.
- Early peer key: peer_pub_valid with B=19 during WAIT_PUB, then a second pulse with B=7 -> second exp_start carries base 19; result ACCEPT with peer_chk=2.
- Parameter and range checks: start with p=2 -> REJECT within 2 cycles and no exp_start. Peer B=22 (p-1) -> REJECT after SEND_PUB.
- Timeout: TIMEOUT=15, never send peer_pub -> status=TIMOUT exactly 15 cycles after WAIT_PEER entry. Also hold exp_done off in WAIT_PUB -> TIMOUT.
- Reset and stray inputs: assert rst during WAIT_SEC -> all outputs 0 next cycle; a late exp_done is ignored. A start pulse while busy is ignored.

Source files
------------

// File: rtl/dh_pkg.sv
// Shared types and constants for the Diffie-Hellman exchange sequencer.
// Includes the FSM state encoding, the ASCII verdict codes and the default operand width.
package dh_pkg;

  localparam int DH_WIDTH = 16;

  localparam logic [47:0] ST_ACCEPT = 48'h414343455054;  // "ACCEPT"
  localparam logic [47:0] ST_REJECT = 48'h52454A454354;  // "REJECT"
  localparam logic [47:0] ST_TIMOUT = 48'h54494D4F5554;  // "TIMOUT"

  typedef enum logic [3:0] {
    S_IDLE,
    S_CALC_PUB,
    S_WAIT_PUB,
    S_SEND_PUB,
    S_WAIT_PEER,
    S_CALC_SEC,
    S_WAIT_SEC,
    S_WAIT_CHK,
    S_DONE
  } dh_state_e;

  function automatic logic is_wait_state(input dh_state_e s);
    return s inside {S_WAIT_PUB, S_WAIT_PEER, S_WAIT_SEC, S_WAIT_CHK};
  endfunction

endpackage

// File: rtl/dh_wait_timer.sv
// Clearable saturating cycle counter; expired_o flags the last allowed counting cycle.
// Combinational flag off registered count, so the FSM can leave on the LIMIT-th cycle it spends waiting.
module dh_wait_timer #(
  parameter int LIMIT = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic inc_i,
  output logic expired_o
);

  localparam int CW = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(LIMIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(LIMIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = inc_i && (cnt_q >= CNT_LAST);

endmodule

// File: rtl/dh_exchange_ctrl.sv
// Sequences one DH exchange over a shared modexp engine: A = g^a mod p, then s = B^a mod p, then peer confirm.
// start -> exp_start and exp_done -> pub_valid are 1 cycle; every wait state aborts after TIMEOUT cycles.
module dh_exchange_ctrl
  import dh_pkg::*;
#(
  parameter int WIDTH   = DH_WIDTH,
  parameter int TIMEOUT = 1023
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] priv_key,
  input  logic [WIDTH-1:0] base_g,
  input  logic [WIDTH-1:0] mod_p,
  input  logic [WIDTH-1:0] peer_pub,
  input  logic             peer_pub_valid,
  input  logic [WIDTH-1:0] peer_chk,
  input  logic             peer_chk_valid,
  output logic             exp_start,
  output logic [WIDTH-1:0] exp_base,
  output logic [WIDTH-1:0] exp_exp,
  output logic [WIDTH-1:0] exp_mod,
  input  logic             exp_done,
  input  logic [WIDTH-1:0] exp_result,
  output logic [WIDTH-1:0] pub_key,
  output logic             pub_valid,
  output logic [WIDTH-1:0] shared_key,
  output logic             busy,
  output logic             done,
  output logic [47:0]      status
);

  dh_state_e        state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             b_vld_q, b_vld_d;
  logic [WIDTH-1:0] pub_q, pub_d;
  logic [WIDTH-1:0] sec_q, sec_d;
  logic [47:0]      status_q, status_d;
  logic [WIDTH-1:0] base_q, base_d;
  logic [WIDTH-1:0] expo_q, expo_d;
  logic [WIDTH-1:0] mod_q, mod_d;

  logic             expired;
  logic             peer_window;
  logic             bad_params;
  logic             b_in_range;
  logic [WIDTH:0]   b_plus2;

  dh_wait_timer #(.LIMIT(TIMEOUT)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (state_d != state_q),
    .inc_i     (is_wait_state(state_q)),
    .expired_o (expired)
  );

  assign peer_window = state_q inside {S_CALC_PUB, S_WAIT_PUB, S_SEND_PUB, S_WAIT_PEER};
  assign bad_params  = (mod_p < WIDTH'(3)) || (priv_key == '0) ||
                       (base_g < WIDTH'(2)) || (base_g >= mod_p);
  // Widened so p-2 never underflows; p >= 3 is already guaranteed here.
  assign b_plus2     = {1'b0, b_q} + (WIDTH+1)'(2);
  assign b_in_range  = (b_q >= WIDTH'(2)) && (b_plus2 <= {1'b0, p_q});

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    p_d      = p_q;
    b_d      = b_q;
    b_vld_d  = b_vld_q;
    pub_d    = pub_q;
    sec_d    = sec_q;
    status_d = status_q;
    base_d   = base_q;
    expo_d   = expo_q;
    mod_d    = mod_q;

    if (peer_window && peer_pub_valid && !b_vld_q) begin
      b_d     = peer_pub;
      b_vld_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d      = priv_key;
          p_d      = mod_p;
          base_d   = base_g;
          expo_d   = priv_key;
          mod_d    = mod_p;
          sec_d    = '0;
          b_vld_d  = 1'b0;
          status_d = '0;
          if (bad_params) begin
            state_d  = S_DONE;
            status_d = ST_REJECT;
          end else begin
            state_d = S_CALC_PUB;
          end
        end
      end
      S_CALC_PUB: state_d = S_WAIT_PUB;
      S_WAIT_PUB: begin
        if (exp_done) begin
          pub_d   = exp_result;
          state_d = S_SEND_PUB;
        end else if (expired) begin
          state_d  = S_DONE;
          status_d = ST_TIMOUT;
        end
      end
      S_SEND_PUB: state_d = S_WAIT_PEER;
      S_WAIT_PEER: begin
        // A B arriving on the expiry cycle is captured and checked next cycle.
        if (b_vld_q) begin
          if (b_in_range) begin
            base_d  = b_q;
            expo_d  = a_q;
            mod_d   = p_q;
            state_d = S_CALC_SEC;
          end else begin
            state_d  = S_DONE;
            status_d = ST_REJECT;
          end
        end else if (!peer_pub_valid && expired) begin
          state_d  = S_DONE;
          status_d = ST_TIMOUT;
        end
      end
      S_CALC_SEC: state_d = S_WAIT_SEC;
      S_WAIT_SEC: begin
        if (exp_done) begin
          sec_d   = exp_result;
          state_d = S_WAIT_CHK;
        end else if (expired) begin
          state_d  = S_DONE;
          status_d = ST_TIMOUT;
        end
      end
      S_WAIT_CHK: begin
        if (peer_chk_valid) begin
          status_d = (peer_chk == sec_q) ? ST_ACCEPT : ST_REJECT;
          state_d  = S_DONE;
        end else if (expired) begin
          state_d  = S_DONE;
          status_d = ST_TIMOUT;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      p_q      <= '0;
      b_q      <= '0;
      b_vld_q  <= 1'b0;
      pub_q    <= '0;
      sec_q    <= '0;
      status_q <= '0;
      base_q   <= '0;
      expo_q   <= '0;
      mod_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      p_q      <= p_d;
      b_q      <= b_d;
      b_vld_q  <= b_vld_d;
      pub_q    <= pub_d;
      sec_q    <= sec_d;
      status_q <= status_d;
      base_q   <= base_d;
      expo_q   <= expo_d;
      mod_q    <= mod_d;
    end
  end

  assign exp_start  = (state_q == S_CALC_PUB) || (state_q == S_CALC_SEC);
  assign exp_base   = base_q;
  assign exp_exp    = expo_q;
  assign exp_mod    = mod_q;
  assign pub_key    = pub_q;
  assign pub_valid  = (state_q == S_SEND_PUB);
  assign shared_key = sec_q;
  assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done       = (state_q == S_DONE);
  assign status     = status_q;

endmodule

// File: tb/tb_dh_exchange_ctrl.sv
// Directed bench for dh_exchange_ctrl with a behavioural 5-cycle modexp engine and TIMEOUT=15.
module tb_dh_exchange_ctrl;

  localparam int W = 16;
  localparam logic [47:0] ACC = 48'h414343455054;
  localparam logic [47:0] REJ = 48'h52454A454354;
  localparam logic [47:0] TMO = 48'h54494D4F5554;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] priv_key = '0, base_g = '0, mod_p = '0;
  logic [W-1:0] peer_pub = '0, peer_chk = '0;
  logic         peer_pub_valid = 1'b0, peer_chk_valid = 1'b0;
  logic         exp_start, exp_done = 1'b0;
  logic [W-1:0] exp_base, exp_exp, exp_mod, exp_result = '0;
  logic [W-1:0] pub_key, shared_key;
  logic         pub_valid, busy, done;
  logic [47:0]  status;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dh_exchange_ctrl #(.WIDTH(W), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .start(start),
    .priv_key(priv_key), .base_g(base_g), .mod_p(mod_p),
    .peer_pub(peer_pub), .peer_pub_valid(peer_pub_valid),
    .peer_chk(peer_chk), .peer_chk_valid(peer_chk_valid),
    .exp_start(exp_start), .exp_base(exp_base), .exp_exp(exp_exp), .exp_mod(exp_mod),
    .exp_done(exp_done), .exp_result(exp_result),
    .pub_key(pub_key), .pub_valid(pub_valid), .shared_key(shared_key),
    .busy(busy), .done(done), .status(status)
  );

  function automatic logic [W-1:0] modexp(input logic [W-1:0] b, input logic [W-1:0] e,
                                           input logic [W-1:0] m);
    longint r = 1;
    longint x = longint'(b) % longint'(m);
    for (int i = 0; i < W; i++) begin
      if (e[i]) r = (r * x) % longint'(m);
      x = (x * x) % longint'(m);
    end
    return W'(r);
  endfunction

  // Engine model: result pulses 5 cycles after exp_start; eng_hold suppresses it.
  int           eng_cnt = 0;
  bit           eng_hold = 1'b0;
  logic [W-1:0] eng_res = '0;
  always @(negedge clk) begin
    exp_done = 1'b0;
    if (exp_start) begin
      eng_res = modexp(exp_base, exp_exp, exp_mod);
      eng_cnt = 5;
    end else if (eng_cnt > 0) begin
      eng_cnt--;
      if (eng_cnt == 0 && !eng_hold) begin
        exp_done   = 1'b1;
        exp_result = eng_res;
      end
    end
  end

  int           n_start = 0, n_pub = 0, n_done = 0;
  logic [W-1:0] last_base = '0;
  always @(posedge clk) begin
    if (exp_start) begin n_start++; last_base = exp_base; end
    if (pub_valid) n_pub++;
    if (done) n_done++;
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_start(input logic [W-1:0] a, input logic [W-1:0] g, input logic [W-1:0] p);
    tick();
    priv_key = a; base_g = g; mod_p = p; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_pub(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (pub_valid) ok = 1'b1;
      else tick();
    end
  endtask

  task automatic wait_secret(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (shared_key !== '0) ok = 1'b1;
      else tick();
    end
  endtask

  task automatic send_peer(input logic [W-1:0] b);
    peer_pub = b; peer_pub_valid = 1'b1;
    tick();
    peer_pub_valid = 1'b0;
  endtask

  task automatic send_chk(input logic [W-1:0] c);
    peer_chk = c; peer_chk_valid = 1'b1;
    tick();
    peer_chk_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (status !== 48'h0) begin errors++; $display("FAIL reset_status: got %h expected 0", status); end
    checks++; if (shared_key !== '0) begin errors++; $display("FAIL reset_shared: got %0d expected 0", shared_key); end
    checks++; if (pub_key !== '0) begin errors++; $display("FAIL reset_pub: got %0d expected 0", pub_key); end
    checks++; if (exp_start !== 1'b0) begin errors++; $display("FAIL reset_exp_start: got %b expected 0", exp_start); end
    rst = 1'b0;
  endtask

  task automatic test_nominal();
    int s0 = n_start, p0 = n_pub, d0 = n_done;
    bit ok;
    do_start(6, 5, 23);
    checks++; if (exp_start !== 1'b1) begin errors++; $display("FAIL nom_exp_start: got %b expected 1", exp_start); end
    checks++; if ({exp_base, exp_exp, exp_mod} !== {16'd5, 16'd6, 16'd23})
      begin errors++; $display("FAIL nom_operands: got %0d,%0d,%0d expected 5,6,23", exp_base, exp_exp, exp_mod); end
    wait_pub(ok);
    checks++; if (!ok) begin errors++; $display("FAIL nom_pub_wait: got no pub_valid expected pulse"); end
    checks++; if (pub_key !== 16'd8) begin errors++; $display("FAIL nom_pub_key: got %0d expected 8", pub_key); end
    send_peer(19);
    wait_secret(ok);
    checks++; if (shared_key !== 16'd2) begin errors++; $display("FAIL nom_shared: got %0d expected 2", shared_key); end
    send_chk(2);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL nom_done: got %b expected 1", done); end
    checks++; if (status !== ACC) begin errors++; $display("FAIL nom_status: got %h expected %h", status, ACC); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nom_busy: got %b expected 0", busy); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL nom_done_pulse: got %b expected 0", done); end
    checks++; if ((n_pub - p0) != 1) begin errors++; $display("FAIL nom_pub_count: got %0d expected 1", n_pub - p0); end
    checks++; if ((n_done - d0) != 1) begin errors++; $display("FAIL nom_done_count: got %0d expected 1", n_done - d0); end
    checks++; if ((n_start - s0) != 2) begin errors++; $display("FAIL nom_start_count: got %0d expected 2", n_start - s0); end
  endtask

  task automatic test_wrong_chk();
    bit ok;
    do_start(6, 5, 23);
    wait_pub(ok);
    send_peer(19);
    wait_secret(ok);
    send_chk(3);
    checks++; if (status !== REJ) begin errors++; $display("FAIL wrong_chk_status: got %h expected %h", status, REJ); end
    checks++; if (shared_key !== 16'd2) begin errors++; $display("FAIL wrong_chk_shared: got %0d expected 2", shared_key); end
  endtask

  task automatic test_early_peer();
    bit ok;
    do_start(6, 5, 23);
    tick();
    send_peer(19);
    send_peer(7);
    wait_pub(ok);
    wait_secret(ok);
    checks++; if (last_base !== 16'd19) begin errors++; $display("FAIL early_base: got %0d expected 19", last_base); end
    checks++; if (shared_key !== 16'd2) begin errors++; $display("FAIL early_shared: got %0d expected 2", shared_key); end
    send_chk(2);
    checks++; if (status !== ACC) begin errors++; $display("FAIL early_status: got %h expected %h", status, ACC); end
  endtask

  task automatic test_param_reject();
    int s0 = n_start;
    do_start(6, 5, 2);
    checks++; if ({done, status} !== {1'b1, REJ}) begin errors++; $display("FAIL p2_reject: got done=%b %h expected 1 %h", done, status, REJ); end
    do_start(6, 23, 23);
    checks++; if ({done, status} !== {1'b1, REJ}) begin errors++; $display("FAIL g_eq_p_reject: got done=%b %h expected 1 %h", done, status, REJ); end
    do_start(0, 5, 23);
    checks++; if ({done, status} !== {1'b1, REJ}) begin errors++; $display("FAIL a0_reject: got done=%b %h expected 1 %h", done, status, REJ); end
    tick(8);
    checks++; if (n_start != s0) begin errors++; $display("FAIL reject_no_exp: got %0d starts expected 0", n_start - s0); end
  endtask

  task automatic test_peer_range();
    int s0 = n_start;
    bit ok;
    do_start(6, 5, 23);
    wait_pub(ok);
    send_peer(22);
    tick();
    checks++; if ({done, status} !== {1'b1, REJ}) begin errors++; $display("FAIL b_pm1_reject: got done=%b %h expected 1 %h", done, status, REJ); end
    checks++; if ((n_start - s0) != 1) begin errors++; $display("FAIL b_pm1_starts: got %0d expected 1", n_start - s0); end
    do_start(6, 5, 23);
    wait_pub(ok);
    send_peer(1);
    tick();
    checks++; if ({done, status} !== {1'b1, REJ}) begin errors++; $display("FAIL b_1_reject: got done=%b %h expected 1 %h", done, status, REJ); end
    do_start(6, 5, 23);
    wait_pub(ok);
    send_peer(21);
    wait_secret(ok);
    checks++; if (shared_key !== 16'd18) begin errors++; $display("FAIL b_pm2_shared: got %0d expected 18", shared_key); end
    send_chk(18);
    checks++; if (status !== ACC) begin errors++; $display("FAIL b_pm2_status: got %h expected %h", status, ACC); end
  endtask

  task automatic test_timeout();
    bit ok;
    do_start(6, 5, 23);
    wait_pub(ok);
    tick(15);
    checks++; if ({busy, done} !== 2'b10) begin errors++; $display("FAIL to_peer_early: got busy,done=%b%b expected 10", busy, done); end
    tick();
    checks++; if ({done, status} !== {1'b1, TMO}) begin errors++; $display("FAIL to_peer: got done=%b %h expected 1 %h", done, status, TMO); end
    eng_hold = 1'b1;
    do_start(6, 5, 23);
    tick(15);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL to_pub_early: got %b expected 0", done); end
    tick();
    checks++; if ({done, status} !== {1'b1, TMO}) begin errors++; $display("FAIL to_pub: got done=%b %h expected 1 %h", done, status, TMO); end
    tick(8);
    eng_hold = 1'b0;
  endtask

  task automatic test_timeout_race();
    bit ok;
    do_start(6, 5, 23);
    wait_pub(ok);
    tick(15);
    send_peer(19);
    checks++; if ({busy, done} !== 2'b10) begin errors++; $display("FAIL race_no_timeout: got busy,done=%b%b expected 10", busy, done); end
    wait_secret(ok);
    checks++; if (shared_key !== 16'd2) begin errors++; $display("FAIL race_shared: got %0d expected 2", shared_key); end
    send_chk(2);
    checks++; if (status !== ACC) begin errors++; $display("FAIL race_status: got %h expected %h", status, ACC); end
  endtask

  task automatic test_reset_stray();
    int s0 = n_start, d0;
    bit ok;
    do_start(6, 5, 23);
    wait_pub(ok);
    send_peer(19);
    for (int i = 0; i < 40 && n_start < s0 + 2; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if ({busy, done, pub_valid, exp_start} !== 4'b0) begin errors++; $display("FAIL rst_ctrl: got %b expected 0000", {busy, done, pub_valid, exp_start}); end
    checks++; if ({shared_key, pub_key, exp_base, exp_mod} !== 64'h0) begin errors++; $display("FAIL rst_data: got %h expected 0", {shared_key, pub_key, exp_base, exp_mod}); end
    checks++; if (status !== 48'h0) begin errors++; $display("FAIL rst_status: got %h expected 0", status); end
    d0 = n_done;
    tick(8);
    checks++; if ({busy, shared_key, pub_key} !== 33'h0 || n_done != d0)
      begin errors++; $display("FAIL late_done: got busy=%b sec=%0d pub=%0d dones=%0d expected 0", busy, shared_key, pub_key, n_done - d0); end
    do_start(6, 5, 23);
    tick(2);
    priv_key = 0; mod_p = 2; start = 1'b1;
    tick();
    start = 1'b0;
    wait_pub(ok);
    checks++; if (pub_key !== 16'd8) begin errors++; $display("FAIL stray_pub: got %0d expected 8", pub_key); end
    send_peer(19);
    wait_secret(ok);
    send_chk(2);
    checks++; if (status !== ACC) begin errors++; $display("FAIL stray_status: got %h expected %h", status, ACC); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_wrong_chk();
    test_early_peer();
    test_param_reject();
    test_peer_range();
    test_timeout();
    test_timeout_race();
    test_reset_stray();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
